mem_channel_arbiter: RTL and testbench

// Sits directly downstream of dcache: takes its per-consumer controller_* read/write requests (misses, write-throughs)
// and multiplexes them onto NUM_CHANNELS external memory channels.

---
 rtl/mem_channel_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_mem_channel_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_channel_arbiter.sv
// mem_channel_arbiter
// Relays per-consumer read/write requests coming from the dcache controller
// lanes onto NUM_CHANNELS independent memory channels. Each channel runs its
// own relay FSM. A shared round-robin pointer decides which consumer an idle
// channel picks up next, so no consumer is starved.
//
// Handshake (both sides): the requester raises valid and holds it until ready
// is seen high; the responder raises ready and holds it until valid drops.
// Payload (address/data) is sampled when the request is granted, and read data
// is valid while ready is high.
//
// Ports
//   clk, reset                     clock; asynchronous active-low reset
//   consumer_read_valid/address    read requests from dcache, one per consumer
//   consumer_read_ready/data       read ack and returned data, per consumer
//   consumer_write_valid/address/data  write requests from dcache
//   consumer_write_ready           write ack, per consumer
//   mem_read_valid/address         read request per memory channel
//   mem_read_ready/data            memory read ack and data per channel
//   mem_write_valid/address/data   write request per memory channel
//   mem_write_ready                memory write ack per channel
//   dbg_chan_state                 current FSM state of every channel
//   dbg_rr_ptr                     current round-robin pointer
module mem_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int WRITE_ENABLE  = 1,
    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CONSUMERS-1:0]                    consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]     consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                    consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                    consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]     consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]     consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                    consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                     mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]      mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                     mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]      mem_read_data,
    output logic [NUM_CHANNELS-1:0]                     mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]      mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]      mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                     mem_write_ready,
    output logic [NUM_CHANNELS-1:0][2:0]                dbg_chan_state,
    output logic [CW-1:0]                               dbg_rr_ptr
);

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_READ_WAITING   = 3'd1,
        S_WRITE_WAITING  = 3'd2,
        S_READ_RELAYING  = 3'd3,
        S_WRITE_RELAYING = 3'd4
    } chan_state_e;

    chan_state_e                             state_q [NUM_CHANNELS];
    chan_state_e                             state_d [NUM_CHANNELS];
    logic [CW-1:0]                           chan_consumer_q [NUM_CHANNELS];
    logic [CW-1:0]                           chan_consumer_d [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]                claim_q, claim_d;
    logic [CW-1:0]                           rr_ptr_q, rr_ptr_d;

    logic [NUM_CHANNELS-1:0]                 mem_read_valid_q, mem_read_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address_q, mem_read_address_d;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid_q, mem_write_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address_q, mem_write_address_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data_q, mem_write_data_d;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready_q, consumer_read_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data_q, consumer_read_data_d;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready_q, consumer_write_ready_d;

    // With writes disabled the write requests are simply never seen, which
    // keeps both write states unreachable and consumer_write_ready at 0.
    logic [NUM_CONSUMERS-1:0] wr_valid;
    assign wr_valid = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

    // Channels are walked in index order and claim_d / rr_ptr_d are updated
    // in place, so a later channel sees every grant and release made by an
    // earlier channel on the same edge and never double-grants a consumer.
    always_comb begin : next_state
        logic          scan_found;
        logic [CW-1:0] scan_sel;
        logic [CW-1:0] scan_idx;
        logic [CW-1:0] cur;

        state_d                = state_q;
        chan_consumer_d        = chan_consumer_q;
        claim_d                = claim_q;
        rr_ptr_d               = rr_ptr_q;
        mem_read_valid_d       = mem_read_valid_q;
        mem_read_address_d     = mem_read_address_q;
        mem_write_valid_d      = mem_write_valid_q;
        mem_write_address_d    = mem_write_address_q;
        mem_write_data_d       = mem_write_data_q;
        consumer_read_ready_d  = consumer_read_ready_q;
        consumer_read_data_d   = consumer_read_data_q;
        consumer_write_ready_d = consumer_write_ready_q;
        scan_found             = 1'b0;
        scan_sel               = '0;
        scan_idx               = '0;
        cur                    = '0;

        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            cur = chan_consumer_q[ch];
            case (state_q[ch])
                S_IDLE: begin
                    // First unclaimed requester at or after rr_ptr, wrapping.
                    scan_found = 1'b0;
                    scan_sel   = '0;
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        scan_idx = CW'((int'(rr_ptr_d) + k) % NUM_CONSUMERS);
                        if (!scan_found && !claim_d[scan_idx] &&
                            (consumer_read_valid[scan_idx] || wr_valid[scan_idx])) begin
                            scan_found = 1'b1;
                            scan_sel   = scan_idx;
                        end
                    end
                    if (scan_found) begin
                        claim_d[scan_sel]   = 1'b1;
                        chan_consumer_d[ch] = scan_sel;
                        rr_ptr_d = (scan_sel == CW'(NUM_CONSUMERS - 1)) ? '0 : scan_sel + 1'b1;
                        // Read wins when a consumer asks for both; its write is
                        // picked up once this claim is released.
                        if (consumer_read_valid[scan_sel]) begin
                            mem_read_valid_d[ch]   = 1'b1;
                            mem_read_address_d[ch] = consumer_read_address[scan_sel];
                            state_d[ch]            = S_READ_WAITING;
                        end else begin
                            mem_write_valid_d[ch]   = 1'b1;
                            mem_write_address_d[ch] = consumer_write_address[scan_sel];
                            mem_write_data_d[ch]    = consumer_write_data[scan_sel];
                            state_d[ch]             = S_WRITE_WAITING;
                        end
                    end
                end
                S_READ_WAITING: begin
                    if (mem_read_ready[ch]) begin
                        mem_read_valid_d[ch]       = 1'b0;
                        consumer_read_data_d[cur]  = mem_read_data[ch];
                        consumer_read_ready_d[cur] = 1'b1;
                        state_d[ch]                = S_READ_RELAYING;
                    end
                end
                S_WRITE_WAITING: begin
                    if (mem_write_ready[ch]) begin
                        mem_write_valid_d[ch]       = 1'b0;
                        consumer_write_ready_d[cur] = 1'b1;
                        state_d[ch]                 = S_WRITE_RELAYING;
                    end
                end
                S_READ_RELAYING: begin
                    if (!consumer_read_valid[cur]) begin
                        consumer_read_ready_d[cur] = 1'b0;
                        consumer_read_data_d[cur]  = '0;
                        claim_d[cur]               = 1'b0;
                        state_d[ch]                = S_IDLE;
                    end
                end
                S_WRITE_RELAYING: begin
                    if (!wr_valid[cur]) begin
                        consumer_write_ready_d[cur] = 1'b0;
                        claim_d[cur]                = 1'b0;
                        state_d[ch]                 = S_IDLE;
                    end
                end
                default: begin
                    state_d[ch] = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch]         <= S_IDLE;
                chan_consumer_q[ch] <= '0;
            end
            claim_q                <= '0;
            rr_ptr_q               <= '0;
            mem_read_valid_q       <= '0;
            mem_read_address_q     <= '0;
            mem_write_valid_q      <= '0;
            mem_write_address_q    <= '0;
            mem_write_data_q       <= '0;
            consumer_read_ready_q  <= '0;
            consumer_read_data_q   <= '0;
            consumer_write_ready_q <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch]         <= state_d[ch];
                chan_consumer_q[ch] <= chan_consumer_d[ch];
            end
            claim_q                <= claim_d;
            rr_ptr_q               <= rr_ptr_d;
            mem_read_valid_q       <= mem_read_valid_d;
            mem_read_address_q     <= mem_read_address_d;
            mem_write_valid_q      <= mem_write_valid_d;
            mem_write_address_q    <= mem_write_address_d;
            mem_write_data_q       <= mem_write_data_d;
            consumer_read_ready_q  <= consumer_read_ready_d;
            consumer_read_data_q   <= consumer_read_data_d;
            consumer_write_ready_q <= consumer_write_ready_d;
        end
    end

    assign mem_read_valid       = mem_read_valid_q;
    assign mem_read_address     = mem_read_address_q;
    assign mem_write_valid      = mem_write_valid_q;
    assign mem_write_address    = mem_write_address_q;
    assign mem_write_data       = mem_write_data_q;
    assign consumer_read_ready  = consumer_read_ready_q;
    assign consumer_read_data   = consumer_read_data_q;
    assign consumer_write_ready = consumer_write_ready_q;
    assign dbg_rr_ptr           = rr_ptr_q;

    always_comb begin
        dbg_chan_state = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            dbg_chan_state[ch] = state_q[ch];
        end
    end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Testbench for mem_channel_arbiter: directed scenarios, a memory responder
// per channel, and a monitor that checks every new memory request and every
// consumer ack against expected queues filled when stimulus is issued.
module tb_mem_channel_arbiter;
    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int NC  = 8;
    localparam int NCH = 2;
    localparam int MW  = 19; // {chk_ch, is_wr, ch, addr[7:0], data[7:0]}
    localparam int AW  = 12; // {is_wr, consumer[2:0], data[7:0]}

    logic clk = 1'b0;
    logic reset;
    logic [NC-1:0]          c_rv, c_rr, c_wv, c_wr;
    logic [NC-1:0][AB-1:0]  c_ra, c_wa;
    logic [NC-1:0][DB-1:0]  c_rd, c_wd;
    logic [NCH-1:0]         m_rv, m_rr, m_wv, m_wr;
    logic [NCH-1:0][AB-1:0] m_ra, m_wa;
    logic [NCH-1:0][DB-1:0] m_rd, m_wd;
    logic [NCH-1:0][2:0]    dbg_state;
    logic [2:0]             dbg_rr;

    int tests = 0;
    int fails = 0;
    int lat [NCH] = '{1, 1};
    int rcnt [NCH] = '{0, 0};
    int wcnt [NCH] = '{0, 0};
    logic [MW-1:0] mem_exp_q[$];
    logic [AW-1:0] ack_exp_q[$];
    logic [NCH-1:0] p_rv = '0, p_wv = '0;
    logic [NC-1:0]  p_rr = '0, p_wr = '0;

    mem_channel_arbiter #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC),
        .NUM_CHANNELS(NCH), .WRITE_ENABLE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
        .mem_read_valid(m_rv), .mem_read_address(m_ra),
        .mem_read_ready(m_rr), .mem_read_data(m_rd),
        .mem_write_valid(m_wv), .mem_write_address(m_wa),
        .mem_write_data(m_wd), .mem_write_ready(m_wr),
        .dbg_chan_state(dbg_state), .dbg_rr_ptr(dbg_rr)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    // Raises ready lat[ch] negedges after it first sees valid, holds it until
    // valid drops. Read data is addr ^ 8'h54.
    initial begin
        m_rr = '0; m_wr = '0; m_rd = '0;
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
                if (!m_rv[ch]) begin
                    m_rr[ch] = 1'b0; rcnt[ch] = 0;
                end else if (!m_rr[ch]) begin
                    rcnt[ch]++;
                    if (rcnt[ch] >= lat[ch]) begin
                        m_rr[ch] = 1'b1;
                        m_rd[ch] = m_ra[ch] ^ 8'h54;
                    end
                end
                if (!m_wv[ch]) begin
                    m_wr[ch] = 1'b0; wcnt[ch] = 0;
                end else if (!m_wr[ch]) begin
                    wcnt[ch]++;
                    if (wcnt[ch] >= lat[ch]) m_wr[ch] = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    task automatic check_mem(input logic wr, input int ch, input logic [7:0] a, input logic [7:0] d);
        logic [MW-1:0] e;
        tests++;
        if (mem_exp_q.size() == 0) begin
            fails++;
            $display("FAIL mem_req: unexpected wr=%0b ch=%0d addr=%h data=%h, none expected", wr, ch, a, d);
        end else begin
            e = mem_exp_q.pop_front();
            if (e[17] != wr || (e[18] && e[16] != ch[0]) || e[15:8] != a || (wr && e[7:0] != d)) begin
                fails++;
                $display("FAIL mem_req: got wr=%0b ch=%0d addr=%h data=%h expected wr=%0b ch=%0d addr=%h data=%h",
                         wr, ch, a, d, e[17], e[16], e[15:8], e[7:0]);
            end
        end
    endtask

    task automatic check_ack(input logic wr, input int c, input logic [7:0] d);
        logic [AW-1:0] e;
        tests++;
        if (ack_exp_q.size() == 0) begin
            fails++;
            $display("FAIL ack: unexpected wr=%0b consumer=%0d data=%h, none expected", wr, c, d);
        end else begin
            e = ack_exp_q.pop_front();
            if (e[11] != wr || e[10:8] != c[2:0] || e[7:0] != d) begin
                fails++;
                $display("FAIL ack: got wr=%0b consumer=%0d data=%h expected wr=%0b consumer=%0d data=%h",
                         wr, c, d, e[11], e[10:8], e[7:0]);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
                if (m_rv[ch] && !p_rv[ch]) check_mem(1'b0, ch, m_ra[ch], 8'h00);
                if (m_wv[ch] && !p_wv[ch]) check_mem(1'b1, ch, m_wa[ch], m_wd[ch]);
            end
            for (int c = 0; c < NC; c++) begin
                if (c_rr[c] && !p_rr[c]) check_ack(1'b0, c, c_rd[c]);
                if (c_wr[c] && !p_wr[c]) check_ack(1'b1, c, 8'h00);
                if (!c_rr[c] && p_rr[c]) check("release_data_cleared", 64'(c_rd[c]), 64'h0);
            end
            p_rv = m_rv; p_wv = m_wv; p_rr = c_rr; p_wr = c_wr;
        end
    end

    // ---------------- consumer drivers ----------------
    task automatic do_read(input int c, input logic [7:0] a);
        int n;
        c_ra[c] = a; c_rv[c] = 1'b1;
        n = 0;
        while (!c_rr[c] && n < 200) begin @(negedge clk); n++; end
        if (!c_rr[c]) begin tests++; fails++; $display("FAIL read_ack_timeout: consumer %0d got no ready, required ready=1", c); end
        c_rv[c] = 1'b0;
        n = 0;
        while (c_rr[c] && n < 200) begin @(negedge clk); n++; end
        if (c_rr[c]) begin tests++; fails++; $display("FAIL read_release_timeout: consumer %0d ready stuck 1, required 0", c); end
    endtask

    task automatic do_write(input int c, input logic [7:0] a, input logic [7:0] d);
        int n;
        c_wa[c] = a; c_wd[c] = d; c_wv[c] = 1'b1;
        n = 0;
        while (!c_wr[c] && n < 200) begin @(negedge clk); n++; end
        if (!c_wr[c]) begin tests++; fails++; $display("FAIL write_ack_timeout: consumer %0d got no ready, required ready=1", c); end
        c_wv[c] = 1'b0;
        n = 0;
        while (c_wr[c] && n < 200) begin @(negedge clk); n++; end
        if (c_wr[c]) begin tests++; fails++; $display("FAIL write_release_timeout: consumer %0d ready stuck 1, required 0", c); end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((mem_exp_q.size() != 0 || ack_exp_q.size() != 0) && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check({name, "_mem_q_empty"}, 64'(mem_exp_q.size()), 64'h0);
        check({name, "_ack_q_empty"}, 64'(ack_exp_q.size()), 64'h0);
        check({name, "_all_idle"}, 64'(dbg_state), 64'h0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset = 1'b0;
        c_rv = '0; c_ra = '0; c_wv = '0; c_wa = '0; c_wd = '0;
        do_reset();

        // Reset state
        check("rst_mem_rv", 64'(m_rv), 64'h0);
        check("rst_mem_wv", 64'(m_wv), 64'h0);
        check("rst_mem_ra", 64'(m_ra), 64'h0);
        check("rst_mem_wa_wd", 64'({m_wa, m_wd}), 64'h0);
        check("rst_c_ready", 64'({c_rr, c_wr}), 64'h0);
        check("rst_c_rdata", 64'(c_rd), 64'h0);
        check("rst_state", 64'(dbg_state), 64'h0);
        check("rst_rr", 64'(dbg_rr), 64'h0);

        // T1 single read with exact latencies
        mem_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'hFF, 8'h00});
        ack_exp_q.push_back({1'b0, 3'd0, 8'hAB});
        c_ra[0] = 8'hFF; c_rv[0] = 1'b1;
        @(negedge clk);
        check("t1_mem_valid", 64'(m_rv), 64'h1);
        check("t1_mem_addr", 64'(m_ra[0]), 64'hFF);
        check("t1_state_rw", 64'(dbg_state[0]), 64'h1);
        check("t1_rr", 64'(dbg_rr), 64'h1);
        @(negedge clk);
        check("t1_ack", 64'(c_rr), 64'h1);
        check("t1_data", 64'(c_rd[0]), 64'hAB);
        check("t1_mem_valid_drop", 64'(m_rv), 64'h0);
        c_rv[0] = 1'b0;
        @(negedge clk);
        check("t1_release_ready", 64'(c_rr), 64'h0);
        check("t1_release_data", 64'(c_rd[0]), 64'h0);
        drain("t1");

        // T2 read on c0 and write on c1 issued together
        do_reset();
        mem_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'hFF, 8'h00});
        mem_exp_q.push_back({1'b1, 1'b1, 1'b1, 8'hF0, 8'hF0});
        ack_exp_q.push_back({1'b0, 3'd0, 8'hAB});
        ack_exp_q.push_back({1'b1, 3'd1, 8'h00});
        fork
            do_read(0, 8'hFF);
            do_write(1, 8'hF0, 8'hF0);
        join
        drain("t2");

        // T3 four readers, two channels, memory latency 2
        do_reset();
        lat[0] = 2; lat[1] = 2;
        mem_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'hA0, 8'h00});
        mem_exp_q.push_back({1'b1, 1'b0, 1'b1, 8'hA1, 8'h00});
        mem_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'hA2, 8'h00});
        mem_exp_q.push_back({1'b1, 1'b0, 1'b1, 8'hA3, 8'h00});
        ack_exp_q.push_back({1'b0, 3'd0, 8'hF4});
        ack_exp_q.push_back({1'b0, 3'd1, 8'hF5});
        ack_exp_q.push_back({1'b0, 3'd2, 8'hF6});
        ack_exp_q.push_back({1'b0, 3'd3, 8'hF7});
        fork
            do_read(0, 8'hA0);
            do_read(1, 8'hA1);
            do_read(2, 8'hA2);
            do_read(3, 8'hA3);
        join
        drain("t3");
        lat[0] = 1; lat[1] = 1;

        // T4 fairness: c0 re-requests at once, c5 and c7 still get in first
        do_reset();
        mem_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h01, 8'h00});
        mem_exp_q.push_back({1'b1, 1'b0, 1'b1, 8'h11, 8'h00});
        mem_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h55, 8'h00});
        mem_exp_q.push_back({1'b1, 1'b0, 1'b1, 8'h77, 8'h00});
        mem_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h02, 8'h00});
        mem_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h03, 8'h00});
        ack_exp_q.push_back({1'b0, 3'd0, 8'h55});
        ack_exp_q.push_back({1'b0, 3'd1, 8'h45});
        ack_exp_q.push_back({1'b0, 3'd5, 8'h01});
        ack_exp_q.push_back({1'b0, 3'd7, 8'h23});
        ack_exp_q.push_back({1'b0, 3'd0, 8'h56});
        ack_exp_q.push_back({1'b0, 3'd0, 8'h57});
        fork
            begin do_read(0, 8'h01); do_read(0, 8'h02); do_read(0, 8'h03); end
            do_read(1, 8'h11);
            do_read(5, 8'h55);
            do_read(7, 8'h77);
        join
        drain("t4");
        check("t4_rr_final", 64'(dbg_rr), 64'h1);

        // T5 read and write on the same consumer: read first, then write
        do_reset();
        mem_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h10, 8'h00});
        mem_exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h20, 8'h55});
        ack_exp_q.push_back({1'b0, 3'd2, 8'h44});
        ack_exp_q.push_back({1'b1, 3'd2, 8'h00});
        fork
            do_read(2, 8'h10);
            do_write(2, 8'h20, 8'h55);
        join
        drain("t5");

        // T6 reset while ch0 waits on memory, then a fresh read
        do_reset();
        lat[0] = 40;
        mem_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h33, 8'h00});
        c_ra[1] = 8'h33; c_rv[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_waiting", 64'(dbg_state[0]), 64'h1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_mem_rv", 64'(m_rv), 64'h0);
        check("t6_async_mem_ra", 64'(m_ra), 64'h0);
        check("t6_async_state", 64'(dbg_state), 64'h0);
        c_rv[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        lat[0] = 1;
        @(negedge clk);
        check("t6_rr_after_reset", 64'(dbg_rr), 64'h0);
        mem_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h44, 8'h00});
        ack_exp_q.push_back({1'b0, 3'd4, 8'h10});
        do_read(4, 8'h44);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        tests++; fails++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
